// File: rtl/pwm_duty_decoder_if.sv
// Signal bundle between a PWM duty decoder and its user: measurement enable,
// the raw PWM line, and the per-window result with its status flags.
interface pwm_duty_decoder_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             pwm_in;
  logic [CNT_W-1:0] duty_out;
  logic             duty_valid;
  logic             duty_changed;
  logic             static_level;
  logic             saturated;

  modport master (
    output en, pwm_in,
    input  duty_out, duty_valid, duty_changed, static_level, saturated
  );

  modport slave (
    input  en, pwm_in,
    output duty_out, duty_valid, duty_changed, static_level, saturated
  );
endinterface

// File: rtl/pwm_duty_decoder.sv
// Recovers the duty of a PWM input as a CNT_W-bit code by counting high samples
// over back-to-back windows of 2^CNT_W clocks (one generator period).
module pwm_duty_decoder #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  pwm_duty_decoder_if.slave   bus
);
  localparam int SW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] duty;
    logic             changed;
    logic             static_lvl;
    logic             sat;
  } result_t;

  state_t               state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 pwm_s, pwm_s_d;
  logic [SW-1:0]        settle_cnt;
  logic [CNT_W-1:0]     win_cnt;
  logic [CNT_W:0]       hi_cnt;
  logic                 edge_seen;
  logic                 first;
  result_t              res;
  logic                 res_valid;

  logic                 edge_now;
  logic                 win_end;
  logic [CNT_W:0]       h_full;
  logic [CNT_W-1:0]     duty_new;

  assign pwm_s    = sync_q[SYNC_STAGES-1];
  assign edge_now = pwm_s ^ pwm_s_d;
  assign win_end  = (state == MEASURE) && (win_cnt == '1);
  // H includes the current sample; all-high windows clamp to the top code
  assign h_full   = hi_cnt + {{CNT_W{1'b0}}, pwm_s};
  assign duty_new = h_full[CNT_W] ? '1 : h_full[CNT_W-1:0];

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.en) state_n = SETTLE;
      // One extra settle cycle covers the IDLE exit, so the synchronizer
      // holds only post-enable samples when the window opens.
      SETTLE:  if (!bus.en) state_n = IDLE;
               else if (settle_cnt == SW'(SYNC_STAGES)) state_n = MEASURE;
      MEASURE: if (!bus.en) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sync_q     <= '0;
      pwm_s_d    <= 1'b0;
      settle_cnt <= '0;
      win_cnt    <= '0;
      hi_cnt     <= '0;
      edge_seen  <= 1'b0;
      first      <= 1'b0;
      res        <= '0;
      res_valid  <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
      pwm_s_d   <= pwm_s;
      state     <= state_n;
      res_valid <= 1'b0;
      case (state)
        SETTLE: begin
          settle_cnt <= settle_cnt + SW'(1);
          win_cnt    <= '0;
          hi_cnt     <= '0;
          edge_seen  <= 1'b0;
          first      <= 1'b1;
        end
        MEASURE: begin
          if (!bus.en) begin
            win_cnt   <= '0;
            hi_cnt    <= '0;
            edge_seen <= 1'b0;
          end else if (win_end) begin
            res.duty       <= duty_new;
            res.sat        <= h_full[CNT_W];
            res.static_lvl <= ~(edge_seen | edge_now);
            res.changed    <= first | (duty_new != res.duty);
            res_valid      <= 1'b1;
            first          <= 1'b0;
            win_cnt        <= '0;
            hi_cnt         <= '0;
            edge_seen      <= 1'b0;
          end else begin
            win_cnt   <= win_cnt + CNT_W'(1);
            hi_cnt    <= h_full;
            edge_seen <= edge_seen | edge_now;
          end
        end
        default: begin
          settle_cnt <= '0;
          win_cnt    <= '0;
          hi_cnt     <= '0;
          edge_seen  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.duty_out     = res.duty;
  assign bus.duty_changed = res.changed;
  assign bus.static_level = res.static_lvl;
  assign bus.saturated    = res.sat;
  assign bus.duty_valid   = res_valid;
endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Scoreboard bench: a window-sum model over the recorded input history predicts
// each update; a negedge monitor checks updates, held outputs and reset values.
module tb_pwm_duty_decoder;
  localparam int CNT_W = 8;
  localparam int S     = 2;
  localparam int WIN   = 1 << CNT_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_duty_decoder_if #(.CNT_W(CNT_W)) bus ();
  pwm_duty_decoder #(.CNT_W(CNT_W), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    int cyc;
    int duty;
    int changed;
    int stat;
    int sat;
  } exp_t;

  exp_t q[$];
  bit   hist[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // stimulus state
  int mode = 0;   // 0 generator, 1 tied high, 2 random bits
  int dim  = 128;
  int gcnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: once enabled at edge e0, an input value seen at edge c
  // is counted at edge c+S; windows of WIN counts close at e0+1+S+WIN*(k+1).
  bit on = 0;
  bit first = 0;
  int e0 = 0;
  int prev_duty = 0;
  always @(posedge clk) begin
    int e;
    e = hist.size();
    hist.push_back(bus.pwm_in);
    if (!rst_n) begin
      on = 0;
      prev_duty = 0;
    end else if (!bus.en) begin
      on = 0;
    end else if (!on) begin
      on = 1;
      e0 = e;
      first = 1;
    end else if ((e - e0) >= 1 + S + WIN && ((e - e0 - 1 - S) % WIN) == 0) begin
      int ones;
      int toggled;
      exp_t x;
      ones = 0;
      toggled = 0;
      for (int j = e - S - WIN + 1; j <= e - S; j++) begin
        ones += int'(hist[j]);
        if (hist[j] != hist[j-1]) toggled = 1;
      end
      x.cyc     = e + 1;
      x.duty    = (ones == WIN) ? WIN - 1 : ones;
      x.sat     = (ones == WIN) ? 1 : 0;
      x.stat    = toggled ? 0 : 1;
      x.changed = (first || x.duty != prev_duty) ? 1 : 0;
      first = 0;
      prev_duty = x.duty;
      q.push_back(x);
    end
  end

  // Monitor
  exp_t held = '{0, 0, 0, 0, 0};
  always @(negedge clk) begin
    int c;
    c = hist.size();
    if (!rst_n) begin
      chk("reset_duty",  int'(bus.duty_out), 0);
      chk("reset_valid", int'(bus.duty_valid), 0);
      chk("reset_flags", int'({bus.duty_changed, bus.static_level, bus.saturated}), 0);
      held = '{0, 0, 0, 0, 0};
    end else begin
      while (q.size() > 0 && q[0].cyc < c) begin
        chk("valid_missing", 0, 1);
        void'(q.pop_front());
      end
      if (bus.duty_valid) begin
        if (q.size() == 0 || q[0].cyc != c) begin
          chk("valid_spurious", 1, 0);
        end else begin
          exp_t x;
          x = q.pop_front();
          chk("duty",         int'(bus.duty_out), x.duty);
          chk("duty_changed", int'(bus.duty_changed), x.changed);
          chk("static_level", int'(bus.static_level), x.stat);
          chk("saturated",    int'(bus.saturated), x.sat);
          held = x;
        end
      end else begin
        chk("hold_duty",  int'(bus.duty_out), held.duty);
        chk("hold_flags", int'({bus.duty_changed, bus.static_level, bus.saturated}),
            (held.changed << 2) | (held.stat << 1) | held.sat);
      end
    end
  end

  // Input driver: moves pwm_in 1 time unit after each edge
  initial begin
    bus.pwm_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      gcnt = (gcnt + 1) % WIN;
      case (mode)
        0:       bus.pwm_in = (gcnt < dim);
        1:       bus.pwm_in = 1'b1;
        default: bus.pwm_in = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_en(input bit v);
    @(posedge clk);
    #1 bus.en = v;
  endtask

  initial begin
    bus.en = 1'b0;
    cycles(3);
    rst_n = 1'b1;

    // steady 128, then the extremes
    set_en(1'b1);
    cycles(1 + S + WIN * 4 + 5);
    dim = 0;   cycles(WIN * 3);
    dim = 255; cycles(WIN * 3);
    mode = 1;  cycles(WIN * 3);

    // dim 77 from random phases of the generator
    mode = 0; dim = 77;
    for (int i = 0; i < 10; i++) begin
      set_en(1'b0);
      cycles($urandom_range(1, WIN));
      set_en(1'b1);
      cycles(1 + S + WIN * 2 + 2);
    end

    // duty change in mid-window
    dim = 50;
    set_en(1'b0);
    set_en(1'b1);
    cycles(1 + S + WIN + 100);
    dim = 200;
    cycles(WIN * 3);

    // en dropped mid-window, then re-enabled
    cycles(100);
    set_en(1'b0);
    cycles(400);
    set_en(1'b1);
    cycles(1 + S + WIN * 2 + 2);

    // reset pulse mid-window: outputs clear immediately
    cycles(120);
    rst_n = 1'b0;
    #1;
    chk("async_reset_duty",  int'(bus.duty_out), 0);
    chk("async_reset_valid", int'(bus.duty_valid), 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(1 + S + WIN * 2 + 2);

    // random sample streams and random duties
    for (int i = 0; i < 6; i++) begin
      mode = $urandom_range(0, 2);
      dim  = $urandom_range(0, WIN - 1);
      cycles($urandom_range(WIN, 2 * WIN));
    end

    set_en(1'b0);
    cycles(5);
    chk("pending_updates", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
